fixp_add_subt_unit: RTL and testbench

- Multi-cycle two's-complement fixed-point adder/subtractor.
- Acts as the responder on the beg_add_subt / ready_add_subt / ack_add_subt handshake driven by the CORDIC control FSM; supplies Xn/Yn/Zn iteration results.
- Sum is computed CHUNK bits per cycle, ripple-carry across cycles, to keep the carry chain short.
- Holds its result stable until acknowledged or until a new request is accepted.

---
 rtl/fixp_add_subt_unit.sv | 121 ++++++++++++
 tb/tb_fixp_add_subt_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixp_add_subt_unit.sv
// Multi-cycle two's-complement fixed-point adder/subtractor.
// The sum is built CHUNK bits per cycle with the carry held in a register
// between cycles. The result is held until acked or until a new request starts.
// Optional build macro: ADD_SUBT_SATURATE_EN clamps overflowed results.
module fixp_add_subt_unit #(
  parameter int unsigned W     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beg_add_subt,
  input  logic         ack_add_subt,
  input  logic         operation,
  input  logic [W-1:0] data_a,
  input  logic [W-1:0] data_b,
  output logic         ready_add_subt,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         busy
);

  localparam int unsigned NCH  = W / CHUNK;
  localparam int unsigned CntW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;      // B already inverted for subtraction
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic            overflow_q, overflow_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0]     base;
  logic [CHUNK:0]  chunk_sum;
  logic            ovf_now;

  // Per-chunk sum of the captured operands plus the carry from the previous chunk.
  always_comb begin
    base      = 32'(cnt_q) * CHUNK;
    chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
  end

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    ovf_now    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (beg_add_subt) begin
          // A new request wins over ack: this is an implicit acknowledge.
          a_d     = data_a;
          b_d     = operation ? ~data_b : data_b;
          carry_d = operation;
          cnt_d   = '0;
          state_d = StCalc;
        end else if (state_q == StDone && ack_add_subt) begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d              = chunk_sum[CHUNK];
        cnt_d                = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          ovf_now    = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
          overflow_d = ovf_now;
          result_d   = acc_d;
`ifdef ADD_SUBT_SATURATE_EN
          if (ovf_now) begin
            result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`endif
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_add_subt = (state_q == StDone);
  assign busy           = (state_q == StCalc);
  assign result         = result_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_fixp_add_subt_unit.sv
// Self-checking bench for fixp_add_subt_unit (W=32, CHUNK=8).
// A transaction-level model predicts outputs every cycle; directed vectors
// pin the model with hand-computed results.
module tb_fixp_add_subt_unit;

  localparam int unsigned W     = 32;
  localparam int unsigned CHUNK = 8;
  localparam int          NCH   = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         beg_add_subt = 1'b0;
  logic         ack_add_subt = 1'b0;
  logic         operation = 1'b0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         ready_add_subt;
  logic [W-1:0] result;
  logic         overflow;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  fixp_add_subt_unit #(.W(W), .CHUNK(CHUNK)) dut (
    .clk            (clk),
    .reset          (reset),
    .beg_add_subt   (beg_add_subt),
    .ack_add_subt   (ack_add_subt),
    .operation      (operation),
    .data_a         (data_a),
    .data_b         (data_b),
    .ready_add_subt (ready_add_subt),
    .result         (result),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: exact signed result, then wrap or clamp.
  task automatic model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          output logic [W-1:0] r, output logic o);
    longint sa, sb, full;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    full = op ? (sa - sb) : (sa + sb);
    o    = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    r    = full[W-1:0];
`ifdef ADD_SUBT_SATURATE_EN
    if (o) r = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
  endtask

  // Transaction model: cycles remaining in the calculation, pending and shown results.
  int           m_left = 0;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_res = '0, p_res = '0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;
  logic         m_started = 1'b0;

  // Advance the model on every active edge using the inputs the DUT sees.
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_ready = 1'b0; m_res = '0; m_ovf = 1'b0; m_started = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1; m_res = p_res; m_ovf = p_ovf;
      end
    end else if (beg_add_subt) begin
      model_op(data_a, data_b, operation, p_res, p_ovf);
      m_left  = NCH;
      m_ready = 1'b0;
    end else if (m_ready && ack_add_subt) begin
      m_ready = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("cyc_ready", W'(ready_add_subt), W'(m_ready));
      check("cyc_busy", W'(busy), W'(m_left > 0));
      check("cyc_result", result, m_res);
      check("cyc_overflow", W'(overflow), W'(m_ovf));
    end
  end

  task automatic wait_ready(output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready_add_subt) return;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_ready: timeout, ready=%b expected 1", ready_add_subt);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input logic [W-1:0] er, input logic eo, input string name);
    int bc;
    data_a = a; data_b = b; operation = op; beg_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
    wait_ready(bc);
    check({name, "_busy_cycles"}, W'(bc), W'(NCH));
    check({name, "_result"}, result, er);
    check({name, "_overflow"}, W'(overflow), W'(eo));
  endtask

  task automatic do_ack();
    ack_add_subt = 1'b1;
    @(negedge clk);
    ack_add_subt = 1'b0;
    check("ack_ready_low", W'(ready_add_subt), 0);
  endtask

  logic [W-1:0] held;
  int           bc;

  initial begin
    // Reset then idle.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_ready", W'(ready_add_subt), 0);
    check("idle_busy", W'(busy), 0);
    check("idle_result", result, 0);
    check("idle_overflow", W'(overflow), 0);

    // Carry crosses a chunk boundary; result held without ack.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "add_carry");
    repeat (5) @(negedge clk);
    check("hold_result", result, 32'h0000_0100);
    check("hold_ready", W'(ready_add_subt), 1);
    do_ack();

    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_neg");
    do_ack();
`ifdef ADD_SUBT_SATURATE_EN
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, "sub_ovf");
    do_ack();
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, "add_ovf");
`else
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, "sub_ovf");
    do_ack();
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, "add_ovf");
`endif
    held = result;

    // Back-to-back: beg and ack together in DONE, beg wins.
    data_a = 32'd3; data_b = 32'd4; operation = 1'b0;
    beg_add_subt = 1'b1; ack_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0; ack_add_subt = 1'b0;
    check("b2b_busy", W'(busy), 1);
    check("b2b_held_result", result, held);
    wait_ready(bc);
    check("b2b_result", result, 32'd7);
    check("b2b_overflow", W'(overflow), 0);

    // Subtract the most negative value: wraps without saturation.
    ack_add_subt = 1'b1;
    @(negedge clk);
    ack_add_subt = 1'b0;
`ifdef ADD_SUBT_SATURATE_EN
    run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1, "sub_minneg");
`else
    run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, "sub_minneg");
`endif
    do_ack();

    // Reset in the second CALC cycle.
    data_a = 32'd1; data_b = 32'd2; operation = 1'b0; beg_add_subt = 1'b1;
    @(negedge clk);
    beg_add_subt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", W'(busy), 0);
    check("rst_mid_ready", W'(ready_add_subt), 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_overflow", W'(overflow), 0);
    repeat (2) @(negedge clk);

    // beg during CALC with different operands is ignored.
    data_a = 32'd10; data_b = 32'd20; operation = 1'b0; beg_add_subt = 1'b1;
    @(negedge clk);
    data_a = 32'd100; data_b = 32'd200; operation = 1'b1;
    repeat (2) @(negedge clk);
    beg_add_subt = 1'b0;
    wait_ready(bc);
    check("calc_beg_ignored", result, 32'd30);
    do_ack();

    // beg held high: the per-cycle model checks the one-cycle ready pulses.
    data_a = 32'd1; data_b = 32'd1; operation = 1'b0; beg_add_subt = 1'b1;
    repeat (15) @(negedge clk);
    beg_add_subt = 1'b0;
    wait_ready(bc);
    check("stream_result", result, 32'd2);
    do_ack();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
